// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Per-frame Pong sequencer: paddles, ball, collisions, score, FSM.
// Revision : 1.0
// ============================================================================
module pong_game_ctrl #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PADDLE_SIZE   = 64,
    parameter int PADDLE_WIDTH  = 16,
    parameter int BALL_SIZE     = 8,
    parameter int BALL_SPEED    = 2,
    parameter int PADDLE_STEP   = 2,
    parameter int SERVE_FRAMES  = 60,
    parameter int WIN_SCORE     = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up1,
    input  logic       btn_dn1,
    input  logic       btn_up2,
    input  logic       btn_dn2,
    input  logic       btn_start,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] state,
    output logic       game_over
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int         CNT_W       = $clog2(SERVE_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    localparam logic [9:0] PADDLE_MAX  = 10'(SCREEN_HEIGHT - PADDLE_SIZE);
    localparam logic [9:0] PADDLE_INIT = 10'((SCREEN_HEIGHT - PADDLE_SIZE) / 2);
    localparam logic [9:0] STEP        = 10'(PADDLE_STEP);
    localparam logic [9:0] CENTRE_X    = 10'(SCREEN_WIDTH / 2);
    localparam logic [9:0] CENTRE_Y    = 10'(SCREEN_HEIGHT / 2);
    localparam logic [9:0] PARK_Y      = 10'(BALL_SIZE);
    localparam logic [9:0] TOP_Y       = 10'(BALL_SIZE);
    localparam logic [9:0] BOT_Y       = 10'(SCREEN_HEIGHT - BALL_SIZE);
    localparam logic [9:0] LHIT_X      = 10'(PADDLE_WIDTH + BALL_SIZE);
    localparam logic [9:0] LMISS_X     = 10'(BALL_SIZE);
    localparam logic [9:0] RHIT_X      = 10'(SCREEN_WIDTH - PADDLE_WIDTH - BALL_SIZE);
    localparam logic [9:0] RMISS_X     = 10'(SCREEN_WIDTH - BALL_SIZE);

    localparam logic signed [11:0] S_BS    = $signed(12'(BALL_SIZE));
    localparam logic signed [11:0] S_H     = $signed(12'(SCREEN_HEIGHT));
    localparam logic signed [11:0] S_PW    = $signed(12'(PADDLE_WIDTH));
    localparam logic signed [11:0] S_RPL   = $signed(12'(SCREEN_WIDTH - PADDLE_WIDTH));
    localparam logic signed [11:0] S_PS    = $signed(12'(PADDLE_SIZE));
    localparam logic signed [11:0] S_SPEED = $signed(12'(BALL_SPEED));
    localparam logic signed [11:0] S_ONE   = 12'sd1;

    logic [2:0]              next_state;
    logic signed [11:0]      vx, vy, nxt_vx, nxt_vy;
    logic                    serve_right, nxt_serve_right;
    logic [CNT_W-1:0]        serve_cnt, nxt_cnt;
    logic [9:0]              nxt_p1, nxt_p2, nxt_bx, nxt_by;
    logic [3:0]              nxt_s1, nxt_s2;

    logic signed [11:0]      bx_s, by_s, p1_s, p2_s, nx, ny;
    logic                    top_hit, bot_hit, left_cross, left_hit, right_cross, right_hit;
    logic                    game_won;

    function automatic logic [9:0] step_paddle(input logic [9:0] y, input logic up,
                                               input logic dn);
        logic [10:0] sum;
        sum = {1'b0, y};
        if (up && !dn) begin
            sum = (y < STEP) ? 11'd0 : sum - {1'b0, STEP};
        end else if (dn && !up) begin
            sum = sum + {1'b0, STEP};
            if (sum > {1'b0, PADDLE_MAX}) sum = {1'b0, PADDLE_MAX};
        end
        return sum[9:0];
    endfunction

    // Collision terms use the pre-tick ball and paddle positions.
    assign bx_s = $signed({2'b00, ball_x});
    assign by_s = $signed({2'b00, ball_y});
    assign p1_s = $signed({2'b00, paddle1_y});
    assign p2_s = $signed({2'b00, paddle2_y});
    assign nx   = bx_s + vx;
    assign ny   = by_s + vy;

    assign top_hit     = (ny - S_BS) <= 12'sd0;
    assign bot_hit     = (ny + S_BS) >= S_H;
    assign left_cross  = vx[11] && ((nx - S_BS) <= S_PW);
    assign left_hit    = ((by_s + S_BS) > p1_s) && ((by_s - S_BS) < (p1_s + S_PS));
    assign right_cross = (vx > 12'sd0) && ((nx + S_BS) >= S_RPL);
    assign right_hit   = ((by_s + S_BS) > p2_s) && ((by_s - S_BS) < (p2_s + S_PS));
    assign game_won    = (score1 == 4'(WIN_SCORE)) || (score2 == 4'(WIN_SCORE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (frame_tick) begin
            case (state)
                ST_IDLE:  if (btn_start) next_state = ST_SERVE;
                ST_SERVE: if (serve_cnt == CNT_LAST) next_state = ST_PLAY;
                ST_PLAY:  if ((left_cross && !left_hit) || (right_cross && !right_hit))
                              next_state = ST_POINT;
                ST_POINT: next_state = game_won ? ST_OVER : ST_SERVE;
                ST_OVER:  if (btn_start) next_state = ST_SERVE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        game_over = (state == ST_OVER);
    end

    always_comb begin
        nxt_p1 = paddle1_y;  nxt_p2 = paddle2_y;
        nxt_bx = ball_x;     nxt_by = ball_y;
        nxt_vx = vx;         nxt_vy = vy;
        nxt_s1 = score1;     nxt_s2 = score2;
        nxt_serve_right = serve_right;
        nxt_cnt = serve_cnt;
        if (frame_tick) begin
            nxt_p1 = step_paddle(paddle1_y, btn_up1, btn_dn1);
            nxt_p2 = step_paddle(paddle2_y, btn_up2, btn_dn2);
            case (state)
                ST_IDLE: begin
                    nxt_bx = CENTRE_X; nxt_by = CENTRE_Y;
                    nxt_vx = '0;       nxt_vy = '0;
                    if (btn_start) begin
                        nxt_s1 = '0; nxt_s2 = '0; nxt_cnt = '0;
                    end
                end
                ST_SERVE: begin
                    nxt_bx = CENTRE_X; nxt_by = CENTRE_Y;
                    nxt_vx = '0;       nxt_vy = '0;
                    if (serve_cnt == CNT_LAST) begin
                        nxt_vx = serve_right ? S_SPEED : -S_SPEED;
                        nxt_vy = serve_right ? S_ONE : -S_ONE;
                    end else begin
                        nxt_cnt = serve_cnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Wall and paddle corrections are independent; both may apply.
                    if (top_hit) begin
                        nxt_by = TOP_Y; nxt_vy = S_ONE;
                    end else if (bot_hit) begin
                        nxt_by = BOT_Y; nxt_vy = -S_ONE;
                    end else begin
                        nxt_by = ny[9:0];
                    end
                    if (left_cross) begin
                        if (left_hit) begin
                            nxt_bx = LHIT_X; nxt_vx = S_SPEED;
                        end else begin
                            nxt_bx = LMISS_X; nxt_vx = '0; nxt_vy = '0;
                            nxt_s2 = score2 + 4'd1; nxt_serve_right = 1'b0;
                        end
                    end else if (right_cross) begin
                        if (right_hit) begin
                            nxt_bx = RHIT_X; nxt_vx = -S_SPEED;
                        end else begin
                            nxt_bx = RMISS_X; nxt_vx = '0; nxt_vy = '0;
                            nxt_s1 = score1 + 4'd1; nxt_serve_right = 1'b1;
                        end
                    end else begin
                        nxt_bx = nx[9:0];
                    end
                end
                ST_POINT: begin
                    nxt_vx = '0; nxt_vy = '0; nxt_cnt = '0;
                    nxt_bx = CENTRE_X;
                    nxt_by = game_won ? PARK_Y : CENTRE_Y;
                end
                ST_OVER: begin
                    nxt_bx = CENTRE_X; nxt_by = PARK_Y;
                    nxt_vx = '0;       nxt_vy = '0;
                    if (btn_start) begin
                        nxt_s1 = '0; nxt_s2 = '0; nxt_cnt = '0;
                        nxt_serve_right = 1'b1;
                        nxt_by = CENTRE_Y;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paddle1_y   <= PADDLE_INIT;
            paddle2_y   <= PADDLE_INIT;
            ball_x      <= CENTRE_X;
            ball_y      <= CENTRE_Y;
            vx          <= '0;
            vy          <= '0;
            score1      <= '0;
            score2      <= '0;
            serve_right <= 1'b1;
            serve_cnt   <= '0;
        end else begin
            paddle1_y   <= nxt_p1;
            paddle2_y   <= nxt_p2;
            ball_x      <= nxt_bx;
            ball_y      <= nxt_by;
            vx          <= nxt_vx;
            vy          <= nxt_vy;
            score1      <= nxt_s1;
            score2      <= nxt_s2;
            serve_right <= nxt_serve_right;
            serve_cnt   <= nxt_cnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Scoreboard bench for pong_game_ctrl against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_up1, btn_dn1, btn_up2, btn_dn2, btn_start;
    logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
    logic [3:0] score1, score2;
    logic [2:0] state;
    logic       game_over;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up1(btn_up1), .btn_dn1(btn_dn1), .btn_up2(btn_up2), .btn_dn2(btn_dn2),
        .btn_start(btn_start),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .ball_x(ball_x), .ball_y(ball_y),
        .score1(score1), .score2(score2),
        .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct { int p1; int p2; int bx; int by; int s1; int s2; int st; int go; } snap_t;
    snap_t sb[$];

    int checks = 0;
    int errors = 0;

    // Frame-level reference model
    int m_st, m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_dir, m_cnt, m_evt;
    int mode1, mode2;   // 0 hold, 1 track ball, 2 avoid ball

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pstep(input int y, input bit up, input bit dn);
        int r;
        r = y;
        if (up && !dn) r = y - 2;
        else if (dn && !up) r = y + 2;
        if (r < 0) r = 0;
        if (r > 416) r = 416;
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_p1 = 208; m_p2 = 208; m_bx = 320; m_by = 240;
        m_vx = 0; m_vy = 0; m_s1 = 0; m_s2 = 0; m_dir = 1; m_cnt = 0; m_evt = 0;
    endtask

    task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
        int nx, ny, op1, op2, obx, oby;
        op1 = m_p1; op2 = m_p2; obx = m_bx; oby = m_by;
        m_evt = 0;
        m_p1 = pstep(m_p1, u1, d1);
        m_p2 = pstep(m_p2, u2, d2);
        case (m_st)
            0: begin
                m_bx = 320; m_by = 240; m_vx = 0; m_vy = 0;
                if (st) begin m_st = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0; end
            end
            1: begin
                m_bx = 320; m_by = 240;
                if (m_cnt == 59) begin m_st = 2; m_vx = 2 * m_dir; m_vy = m_dir; end
                else begin m_vx = 0; m_vy = 0; m_cnt++; end
            end
            2: begin
                nx = obx + m_vx; ny = oby + m_vy;
                if (ny - 8 <= 0) begin m_by = 8; m_vy = 1; end
                else if (ny + 8 >= 480) begin m_by = 472; m_vy = -1; end
                else m_by = ny;
                if (m_vx < 0 && nx - 8 <= 16) begin
                    if (oby + 8 > op1 && oby - 8 < op1 + 64) begin m_bx = 24; m_vx = 2; m_evt = 1; end
                    else begin m_bx = 8; m_s2++; m_dir = -1; m_st = 3; m_evt = 3; end
                end else if (m_vx > 0 && nx + 8 >= 624) begin
                    if (oby + 8 > op2 && oby - 8 < op2 + 64) begin m_bx = 616; m_vx = -2; m_evt = 2; end
                    else begin m_bx = 632; m_s1++; m_dir = 1; m_st = 3; m_evt = 4; end
                end else m_bx = nx;
            end
            3: begin
                m_vx = 0; m_vy = 0; m_cnt = 0; m_bx = 320;
                if (m_s1 == 9 || m_s2 == 9) begin m_st = 4; m_by = 8; end
                else begin m_st = 1; m_by = 240; end
            end
            default: begin
                m_bx = 320; m_by = 8; m_vx = 0; m_vy = 0;
                if (st) begin
                    m_st = 1; m_s1 = 0; m_s2 = 0; m_dir = 1; m_cnt = 0; m_by = 240;
                end
            end
        endcase
    endtask

    task automatic compare_front();
        snap_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("paddle1_y", 32'(paddle1_y), e.p1);
            check("paddle2_y", 32'(paddle2_y), e.p2);
            check("ball_x",    32'(ball_x),    e.bx);
            check("ball_y",    32'(ball_y),    e.by);
            check("score1",    32'(score1),    e.s1);
            check("score2",    32'(score2),    e.s2);
            check("state",     32'(state),     e.st);
            check("game_over", 32'(game_over), e.go);
        end
    endtask

    task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
        snap_t e;
        @(negedge clk);
        btn_up1 = u1; btn_dn1 = d1; btn_up2 = u2; btn_dn2 = d2; btn_start = st;
        frame_tick = 1'b1;
        model_tick(u1, d1, u2, d2, st);
        e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
        e.s1 = m_s1; e.s2 = m_s2; e.st = m_st; e.go = (m_st == 4) ? 1 : 0;
        sb.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        btn_up1 = 0; btn_dn1 = 0; btn_up2 = 0; btn_dn2 = 0; btn_start = 0;
        compare_front();
        @(negedge clk);
        check("hold_ball_x", 32'(ball_x), m_bx);
        check("hold_p2", 32'(paddle2_y), m_p2);
    endtask

    function automatic bit [1:0] steer(input int mode, input int py);
        int c;
        c = py + 32;
        if (mode == 1) begin
            if (c < m_by - 1) return 2'b01;
            if (c > m_by + 1) return 2'b10;
            return 2'b00;
        end else if (mode == 2) begin
            return (c >= m_by) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic game_tick(input bit st);
        bit [1:0] a, b;
        a = steer(mode1, m_p1);
        b = steer(mode2, m_p2);
        do_tick(a[1], a[0], b[1], b[0], st);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_p1"}, 32'(paddle1_y), 208);
        check({tag, "_p2"}, 32'(paddle2_y), 208);
        check({tag, "_bx"}, 32'(ball_x), 320);
        check({tag, "_by"}, 32'(ball_y), 240);
        check({tag, "_s1"}, 32'(score1), 0);
        check({tag, "_s2"}, 32'(score2), 0);
        check({tag, "_st"}, 32'(state), 0);
        check({tag, "_go"}, 32'(game_over), 0);
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b1; frame_tick = 0;
        btn_up1 = 0; btn_dn1 = 0; btn_up2 = 0; btn_dn2 = 0; btn_start = 0;
        mode1 = 0; mode2 = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        // Paddle stepping and clamping
        for (int i = 1; i <= 3; i++) begin
            do_tick(1, 0, 0, 0, 0);
            check("p1_step", 32'(paddle1_y), 208 - 2 * i);
        end
        repeat (110) do_tick(1, 0, 0, 0, 0);
        check("p1_clamp0", 32'(paddle1_y), 0);
        repeat (120) do_tick(0, 0, 0, 1, 0);
        check("p2_clamp416", 32'(paddle2_y), 416);
        do_tick(1, 1, 0, 0, 0);
        check("p1_both_hold", 32'(paddle1_y), 0);

        // Serve sequence
        mode1 = 1; mode2 = 1;
        game_tick(1);
        check("serve_state", 32'(state), 1);
        repeat (59) game_tick(0);
        check("serve_wait", 32'(state), 1);
        game_tick(0);
        check("play_state", 32'(state), 2);
        game_tick(0);
        check("first_step_x", 32'(ball_x), 322);
        check("first_step_y", 32'(ball_y), 241);

        // Right paddle hit, then left paddle hit
        seen = 0; n = 0;
        while (!seen && n < 400) begin game_tick(0); n++; seen = (m_evt == 2); end
        check("rhit_seen", 32'(seen), 1);
        check("rhit_x", 32'(ball_x), 616);
        check("rhit_scores", 32'({score1, score2}), 0);
        seen = 0; n = 0;
        while (!seen && n < 400) begin game_tick(0); n++; seen = (m_evt == 1); end
        check("lhit_seen", 32'(seen), 1);
        check("lhit_x", 32'(ball_x), 24);

        // Right-hand misses until player 1 wins
        mode2 = 2;
        seen = 0; n = 0;
        while (!seen && n < 1500) begin game_tick(0); n++; seen = (m_evt == 4); end
        check("miss_seen", 32'(seen), 1);
        check("miss_score1", 32'(score1), 1);
        check("miss_state", 32'(state), 3);
        game_tick(0);
        check("point_to_serve", 32'(state), 1);
        repeat (60) game_tick(0);
        game_tick(0);
        check("reserve_dir_x", 32'(ball_x), 322);

        n = 0;
        while (m_st != 4 && n < 6000) begin game_tick(0); n++; end
        check("over_state", 32'(state), 4);
        check("over_flag", 32'(game_over), 1);
        check("over_s1", 32'(score1), 9);
        check("park_x", 32'(ball_x), 320);
        check("park_y", 32'(ball_y), 8);
        game_tick(1);
        check("restart_state", 32'(state), 1);
        check("restart_s1", 32'(score1), 0);

        // Asynchronous reset mid-rally
        repeat (70) game_tick(0);
        check("pre_reset_play", 32'(state), 2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("arst");
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        do_tick(1, 0, 0, 0, 0);
        check("post_reset_tick", 32'(paddle1_y), 206);
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-rate game sequencer for the Pong display path. Once per video frame it advances paddle positions from button inputs, steps the ball, resolves wall and paddle collisions, keeps score, and runs the serve/play/game-over sequence. It runs on the pixel clock and feeds the colour-generation logic: paddle, ball and score registers only, no pixel output.

## Interface
Parameters:
- SCREEN_WIDTH, 640, active width in pixels
- SCREEN_HEIGHT, 480, active height in lines
- PADDLE_SIZE, 64, paddle height
- PADDLE_WIDTH, 16, paddle thickness; the paddle plane is at x = PADDLE_WIDTH (left) and x = SCREEN_WIDTH-PADDLE_WIDTH (right)
- BALL_SIZE, 8, ball half-extent
- BALL_SPEED, 2, ball x step per frame; the y step is always 1
- PADDLE_STEP, 2, paddle step per frame
- SERVE_FRAMES, 60, frames the ball waits centred before a serve
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- btn_up1, btn_dn1, btn_up2, btn_dn2  in  1 each  paddle controls, already synchronised, sampled only on frame_tick
- btn_start  in  1  start/restart, sampled only on frame_tick
- paddle1_y, paddle2_y  out  10  paddle top edge
- ball_x, ball_y  out  10  ball centre
- score1, score2  out  4  scores
- state  out  3  FSM state encoding
- game_over  out  1  high in OVER

## Operation
- Reset values:
  - state = IDLE
  - paddle1_y = paddle2_y = (SCREEN_HEIGHT-PADDLE_SIZE)/2 = 208
  - ball = (320,240)
  - velocity = 0
  - scores = 0
  - serve_dir = +1 (toward player 2)
  - frame counter = 0
  - game_over = 0
- All state changes happen only in the cycle after a frame_tick. Between ticks every output holds.
- Paddle motion on every tick, in every state:
  - up alone: y -= PADDLE_STEP
  - down alone: y += PADDLE_STEP
  - both or neither: hold
  - result clamped to 0..SCREEN_HEIGHT-PADDLE_SIZE (0..416)
- State encodings: IDLE 0, SERVE 1, PLAY 2, POINT 3, OVER 4.
- IDLE: ball centred, velocity 0. btn_start -> SERVE, scores cleared, frame counter 0.
- SERVE: ball centred, velocity 0. The counter increments per tick. When the counter reaches SERVE_FRAMES-1 -> PLAY with vx = serve_dir*BALL_SPEED and vy = serve_dir*1.
- PLAY, each tick, using pre-tick ball and paddle values. Arithmetic is signed 12-bit with next = pos + vel.
  - Top wall: next_y - BALL_SIZE <= 0 -> ball_y = BALL_SIZE, vy = +1.
  - Bottom wall: next_y + BALL_SIZE >= SCREEN_HEIGHT -> ball_y = SCREEN_HEIGHT-BALL_SIZE, vy = -1.
  - Left plane: vx < 0 and next_x - BALL_SIZE <= PADDLE_WIDTH.
    - Hit when ball_y+BALL_SIZE > paddle1_y and ball_y-BALL_SIZE < paddle1_y+PADDLE_SIZE: ball_x = PADDLE_WIDTH+BALL_SIZE, vx = +BALL_SPEED.
    - Otherwise miss: ball_x = BALL_SIZE, score2 += 1, serve_dir = -1, -> POINT.
  - Right plane: mirror of the left plane with paddle2. A hit leaves ball_x = SCREEN_WIDTH-PADDLE_WIDTH-BALL_SIZE. A miss sets score1 += 1, serve_dir = +1.
  - Wall and paddle checks resolve independently in the same tick (corner case: both the y and x corrections apply).
- POINT: lasts one tick, with velocity 0.
  - Either score == WIN_SCORE -> OVER.
  - Otherwise -> SERVE with counter 0.
- OVER: game_over = 1, ball parked at (SCREEN_WIDTH/2, BALL_SIZE). btn_start -> SERVE with scores cleared, serve_dir = +1.
- btn_start is ignored in SERVE, PLAY and POINT.
- Scores never exceed WIN_SCORE. No 4-bit wrap is possible.

## Timing
- Latency: outputs reflect a tick one clk after frame_tick is sampled high.
- frame_tick pulses closer together than 2 clk are not supported. Each sampled-high cycle counts as one tick.
- Reset is asynchronous: outputs go to reset values immediately, mid-frame or mid-rally. The first tick after deassertion is processed normally.
- Outputs are registered with no combinational path from inputs.

## Test plan
- Reset, then 3 ticks with btn_up1 held: paddle1_y 208 -> 206 -> 204 -> 202. After 110 more ticks it clamps at 0. btn_dn2 held for 120 ticks: paddle2_y clamps at 416.
- btn_start on a tick in IDLE: state = 1 (SERVE). After 60 ticks: state = 2, vx = +2, vy = +1, ball (320,240) -> (322,241) on the next tick.
- Ball set up to cross the right plane with paddle2 overlapping: ball_x clamps to 616, vx = -2, scores unchanged.
- Same approach with paddle2 at 0 and ball_y at 400: miss, score1 = 1, state 3 then 1, and the next serve has vx = +2.
- Drive score1 to 9 via repeated misses: state = 4, game_over = 1, ball at (320,8). btn_start clears scores and gives state = 1.
- Assert reset for 1 cycle mid-PLAY: all outputs return to reset values the same cycle, and state = 0.
